// File: rtl/priority_encoder_16_to_4.sv
// Registered 16-to-4 priority encoder with sticky request capture and an ack handshake.
// Requests accumulate in a pending register; the winning index is presented until acked.
module priority_encoder_16_to_4 #(
    parameter int unsigned LOW_FIRST = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    input  logic        ack,
    output logic [3:0]  code,
    output logic        valid,
    output logic [15:0] pending,
    output logic [4:0]  pend_cnt
);

    logic [15:0] pending_r;
    logic [3:0]  code_r;
    logic        valid_r;
    logic [4:0]  pend_cnt_r;

    logic [15:0] clr_s;
    logic [15:0] pend_nx_s;
    logic [3:0]  code_nx_s;
    logic        valid_nx_s;
    logic [4:0]  pend_cnt_nx_s;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 0; i < 16; i++) begin
            c = c + {4'd0, v[i]};
        end
        return c;
    endfunction

    // Ascending scan: the last set bit seen is the highest; empty vector yields 0.
    function automatic logic [3:0] enc_high(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    function automatic logic [3:0] enc_low(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Retire the presented winner on ack, merge new requests (set wins), pick the next winner.
    always_comb begin
        clr_s = 16'h0000;
        if (valid_r && ack) begin
            clr_s = 16'h0001 << code_r;
        end else begin
            clr_s = 16'h0000;
        end
        pend_nx_s = (pending_r & ~clr_s) | req;
        if (LOW_FIRST != 0) begin
            code_nx_s = enc_low(pend_nx_s);
        end else begin
            code_nx_s = enc_high(pend_nx_s);
        end
        valid_nx_s    = |pend_nx_s;
        pend_cnt_nx_s = popcount16(pend_nx_s);
    end

    // State and outputs load together so they always describe the same pending value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_r  <= 16'h0000;
            code_r     <= 4'h0;
            valid_r    <= 1'b0;
            pend_cnt_r <= 5'd0;
        end else begin
            pending_r  <= pend_nx_s;
            code_r     <= code_nx_s;
            valid_r    <= valid_nx_s;
            pend_cnt_r <= pend_cnt_nx_s;
        end
    end

    assign pending  = pending_r;
    assign code     = code_r;
    assign valid    = valid_r;
    assign pend_cnt = pend_cnt_r;

endmodule

// File: tb/tb_priority_encoder_16_to_4.sv
// Scoreboard bench for priority_encoder_16_to_4: one instance per priority order,
// directed vectors push hand-computed expectations, a monitor pops and compares.
module tb_priority_encoder_16_to_4;

    logic        clk;
    logic        rst;
    logic [15:0] req_h, req_l;
    logic        ack_h, ack_l;
    logic [3:0]  code_h, code_l;
    logic        valid_h, valid_l;
    logic [15:0] pending_h, pending_l;
    logic [4:0]  cnt_h, cnt_l;

    int tests;
    int fails;

    typedef struct {
        string       name;
        bit          lo;
        logic [3:0]  code;
        logic        valid;
        logic [15:0] pending;
        logic [4:0]  cnt;
    } exp_t;

    exp_t sb[$];

    priority_encoder_16_to_4 #(.LOW_FIRST(0)) dut_h (
        .clk(clk), .rst(rst), .req(req_h), .ack(ack_h),
        .code(code_h), .valid(valid_h), .pending(pending_h), .pend_cnt(cnt_h)
    );

    priority_encoder_16_to_4 #(.LOW_FIRST(1)) dut_l (
        .clk(clk), .rst(rst), .req(req_l), .ack(ack_l),
        .code(code_l), .valid(valid_l), .pending(pending_l), .pend_cnt(cnt_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every edge that has an outstanding expectation is checked 1 time unit later.
    always @(posedge clk) begin
        exp_t e;
        logic [3:0]  ac;
        logic        av;
        logic [15:0] ap;
        logic [4:0]  an;
        #1;
        if (sb.size() > 0) begin
            e  = sb.pop_front();
            ac = e.lo ? code_l    : code_h;
            av = e.lo ? valid_l   : valid_h;
            ap = e.lo ? pending_l : pending_h;
            an = e.lo ? cnt_l     : cnt_h;
            tests++;
            if (ac !== e.code || av !== e.valid || ap !== e.pending || an !== e.cnt) begin
                fails++;
                $display("FAIL %s: got code=%0d valid=%0b pending=%h cnt=%0d, want code=%0d valid=%0b pending=%h cnt=%0d",
                         e.name, ac, av, ap, an, e.code, e.valid, e.pending, e.cnt);
            end
        end
    end

    task automatic step(input string name, input bit lo, input logic [15:0] r, input logic a,
                        input logic [3:0] c, input logic v, input logic [15:0] p, input logic [4:0] n);
        exp_t e;
        @(negedge clk);
        req_h = lo ? 16'h0000 : r;
        ack_h = lo ? 1'b0 : a;
        req_l = lo ? r : 16'h0000;
        ack_l = lo ? a : 1'b0;
        e.name = name; e.lo = lo; e.code = c; e.valid = v; e.pending = p; e.cnt = n;
        sb.push_back(e);
    endtask

    task automatic check_zero(input string name);
        tests++;
        if (code_h !== 4'h0 || valid_h !== 1'b0 || pending_h !== 16'h0000 || cnt_h !== 5'd0 ||
            code_l !== 4'h0 || valid_l !== 1'b0 || pending_l !== 16'h0000 || cnt_l !== 5'd0) begin
            fails++;
            $display("FAIL %s: got hi code=%0d valid=%0b pending=%h cnt=%0d lo code=%0d valid=%0b pending=%h cnt=%0d, want all zero",
                     name, code_h, valid_h, pending_h, cnt_h, code_l, valid_l, pending_l, cnt_l);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        req_h = 16'h0000; ack_h = 1'b0;
        req_l = 16'h0000; ack_l = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset_init");
        rst = 1'b0;

        // Full, then asynchronous reset between edges
        step("full",           1'b0, 16'hFFFF, 1'b0, 4'd15, 1'b1, 16'hFFFF, 5'd16);
        step("full_hold",      1'b0, 16'h0000, 1'b0, 4'd15, 1'b1, 16'hFFFF, 5'd16);
        step("full_lo",        1'b1, 16'hFFFF, 1'b0, 4'd0,  1'b1, 16'hFFFF, 5'd16);
        @(negedge clk);
        req_l = 16'h0000;
        #2 rst = 1'b1;
        #1 check_zero("async_reset");
        @(negedge clk);
        rst = 1'b0;
        step("post_reset",     1'b0, 16'h0000, 1'b0, 4'd0,  1'b0, 16'h0000, 5'd0);

        // Single request and ack
        step("single",         1'b0, 16'h0020, 1'b0, 4'd5,  1'b1, 16'h0020, 5'd1);
        step("single_ack",     1'b0, 16'h0000, 1'b1, 4'd0,  1'b0, 16'h0000, 5'd0);

        // Priority and drain, highest first
        step("drain_h_load",   1'b0, 16'h8421, 1'b0, 4'd15, 1'b1, 16'h8421, 5'd4);
        step("drain_h_1",      1'b0, 16'h0000, 1'b1, 4'd10, 1'b1, 16'h0421, 5'd3);
        step("drain_h_2",      1'b0, 16'h0000, 1'b1, 4'd5,  1'b1, 16'h0021, 5'd2);
        step("drain_h_3",      1'b0, 16'h0000, 1'b1, 4'd0,  1'b1, 16'h0001, 5'd1);
        step("drain_h_4",      1'b0, 16'h0000, 1'b1, 4'd0,  1'b0, 16'h0000, 5'd0);

        // Priority and drain, lowest first
        step("drain_l_load",   1'b1, 16'h8421, 1'b0, 4'd0,  1'b1, 16'h8421, 5'd4);
        step("drain_l_1",      1'b1, 16'h0000, 1'b1, 4'd5,  1'b1, 16'h8420, 5'd3);
        step("drain_l_2",      1'b1, 16'h0000, 1'b1, 4'd10, 1'b1, 16'h8400, 5'd2);
        step("drain_l_3",      1'b1, 16'h0000, 1'b1, 4'd15, 1'b1, 16'h8000, 5'd1);
        step("drain_l_4",      1'b1, 16'h0000, 1'b1, 4'd0,  1'b0, 16'h0000, 5'd0);

        // Preemption
        step("preempt_base",   1'b0, 16'h0008, 1'b0, 4'd3,  1'b1, 16'h0008, 5'd1);
        step("preempt",        1'b0, 16'h0100, 1'b0, 4'd8,  1'b1, 16'h0108, 5'd2);
        step("preempt_hold",   1'b0, 16'h0000, 1'b0, 4'd8,  1'b1, 16'h0108, 5'd2);
        step("preempt_lo_a",   1'b1, 16'h0010, 1'b0, 4'd4,  1'b1, 16'h0010, 5'd1);
        step("preempt_lo_b",   1'b1, 16'h0002, 1'b0, 4'd1,  1'b1, 16'h0012, 5'd2);
        step("preempt_lo_ack", 1'b1, 16'h0000, 1'b1, 4'd4,  1'b1, 16'h0010, 5'd1);
        step("preempt_lo_end", 1'b1, 16'h0000, 1'b1, 4'd0,  1'b0, 16'h0000, 5'd0);

        // Simultaneous set and clear of the presented bit
        step("ack_8",          1'b0, 16'h0000, 1'b1, 4'd3,  1'b1, 16'h0008, 5'd1);
        step("req_7",          1'b0, 16'h0080, 1'b0, 4'd7,  1'b1, 16'h0088, 5'd2);
        step("set_clr_7",      1'b0, 16'h0080, 1'b1, 4'd7,  1'b1, 16'h0088, 5'd2);
        step("ack_7",          1'b0, 16'h0000, 1'b1, 4'd3,  1'b1, 16'h0008, 5'd1);
        step("ack_3",          1'b0, 16'h0000, 1'b1, 4'd0,  1'b0, 16'h0000, 5'd0);

        // Ack while idle is ignored
        step("idle_ack_1",     1'b0, 16'h0000, 1'b1, 4'd0,  1'b0, 16'h0000, 5'd0);
        step("idle_ack_2",     1'b0, 16'h0000, 1'b1, 4'd0,  1'b0, 16'h0000, 5'd0);
        step("idle_req_merge", 1'b0, 16'h0201, 1'b0, 4'd9,  1'b1, 16'h0201, 5'd2);
        step("merge_repeat",   1'b0, 16'h0201, 1'b0, 4'd9,  1'b1, 16'h0201, 5'd2);

        // Reset mid-operation discards pending requests
        @(negedge clk);
        req_h = 16'h0000;
        ack_h = 1'b0;
        #3 rst = 1'b1;
        #1 check_zero("reset_mid_op");
        @(negedge clk);
        rst = 1'b0;
        step("after_mid_reset", 1'b0, 16'h0000, 1'b0, 4'd0, 1'b0, 16'h0000, 5'd0);
        step("after_reset_req", 1'b0, 16'h4000, 1'b0, 4'd14, 1'b1, 16'h4000, 5'd1);

        @(negedge clk);
        req_h = 16'h0000;
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d outstanding, want 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/priority_encoder_16_to_4.md
# priority_encoder_16_to_4

Registered 16-to-4 priority encoder with sticky request capture and an acknowledge handshake: the inverse of the 4-to-16 decoder. Sixteen request lines are latched into a pending register. The block presents the binary index of the winning pending request with a valid flag. An acknowledge retires that request. It sits between event sources (buttons, lab peripherals, decoder-driven selects) and a consumer that services one indexed event at a time.

## Interface
Parameters:
- LOW_FIRST, default 0. 0: highest pending index wins. 1: lowest pending index wins.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  16  request lines, sampled every rising edge; a 1 sets the matching pending bit (a pulse or a level both work).
- ack  input  1  consumer accepts the currently presented code; honoured only when valid=1.
- code  output  4  binary index of the winning pending request.
- valid  output  1  1 when at least one request is pending.
- pending  output  16  current contents of the pending register.
- pend_cnt  output  5  number of set bits in pending, range 0..16.

## Operation
- State: pending[15:0], plus registered outputs code, valid and pend_cnt.
- Clear mask: clr = one-hot(code) when valid && ack; otherwise clr = 0.
- Next pending: pend_nx = (pending & ~clr) | req.
- Winner: code_nx = index of the highest set bit of pend_nx (LOW_FIRST=0) or the lowest set bit (LOW_FIRST=1).
  - valid_nx = |pend_nx.
  - If pend_nx == 0, then code_nx = 0.
- Count: pend_cnt_nx = popcount(pend_nx), computed at 5-bit width; 16 → 5'b10000, no wrap.
- At each rising edge, pending, code, valid and pend_cnt all load their _nx values together. The outputs therefore always describe the registered pending value.
- ack while valid=0: ignored, no state change.
- Same bit requested and cleared in one cycle: the set wins, so the bit stays pending. This is a new occurrence, not lost.
- Requests for bits already pending merge (no counting of repeats).
- Preemption is allowed. A new higher-priority request changes code on the next edge even if the consumer has not acked. The consumer must sample code in the same cycle it asserts ack.
- There is no FSM beyond the pending register. The two effective states are:
  - IDLE (valid=0): any req bit moves it to BUSY.
  - BUSY (valid=1): an ack that empties pending, with no new req, moves it back to IDLE.

## Timing
- Reset (rst=1, asynchronous, immediate):
  - pending = 16'h0000, code = 4'h0, valid = 0, pend_cnt = 0.
  - req and ack are ignored while rst=1.
- Reset mid-operation discards all pending requests.
- The first edge after rst deasserts samples req normally.
- Latency:
  - req asserted before edge N: valid/code/pending reflect it after edge N (1 cycle).
  - ack asserted before edge N: the retired bit is cleared, and the next winner is presented, after edge N. This allows back-to-back acks, one retirement per cycle.
- Outputs are glitch-free registered values; there is no combinational path from req or ack to any output.

## Test plan
- Reset check: assert rst asynchronously between edges while pending=16'hFFFF -> all outputs are 0 immediately; release rst with req=0 -> everything stays 0.
- Single request (LOW_FIRST=0): pulse req=16'h0020 for one cycle -> next cycle valid=1, code=5, pend_cnt=1. Assert ack for one cycle -> valid=0, code=0, pend_cnt=0.
- Priority and drain: req=16'h8421 for one cycle, then hold ack high -> code sequence 15, 10, 5, 0 on consecutive cycles, pend_cnt 4,3,2,1, then valid=0. With LOW_FIRST=1 the sequence is 0, 5, 10, 15.
- Preemption: bit 3 pending, no ack; pulse req=16'h0100 -> next cycle code=8, pending=16'h0108, pend_cnt=2.
- Simultaneous set/clear: code=7 presented, ack=1 and req=16'h0080 in the same cycle -> bit 7 stays pending, code=7, valid=1, pend_cnt unchanged.
- Full and ignored ack: req=16'hFFFF -> pend_cnt=16, code=15. Separately, ack while valid=0 -> no change.
